pb_i2c_arbiter: RTL
===================

Name: pb_i2c_arbiter

Overview:
Shares the single Power Board I2C master engine between two requesters: the CAM opcode handler (req 0) and a housekeeping battery-monitor poller (req 1). Each requester uses the existing start/status handshake. The arbiter grants one requester and latches its command. It replays the handshake to the engine and returns the read data and handshake status to the granted requester only. It sits between cam, the housekeeping block and the pb I2C engine.

Parameters:
TIMEOUT_CYCLES, 2_000_000, engine watchdog limit in clk cycles (20 ms at 100 MHz); used only with the optional feature.
TO_CNT_W, 21, width of the watchdog counter; 2^TO_CNT_W must be greater than TIMEOUT_CYCLES.

Ports:
clk  in  1  100 MHz main clock
n_reset  in  1  synchronous, active-low reset
cam_start  in  1  request 0 start, level
cam_type  in  4  request 0 transaction type (0 write, 1 read, 2 read with repeated start)
cam_cmd  in  32  request 0 {arg1, arg0, pay1, pay0}
cam_status  out  1  request 0 busy status
cam_rd_data  out  16  request 0 read result {data0, data1}
hk_start  in  1  request 1 start, level
hk_type  in  4  request 1 transaction type
hk_cmd  in  32  request 1 command
hk_status  out  1  request 1 busy status
hk_rd_data  out  16  request 1 read result
lock_hk  in  1  when high, request 1 is never granted (power-down in progress)
i2c_start  out  1  to engine
i2c_type  out  4  to engine
i2c_cmd  out  32  to engine
i2c_status  in  1  from engine: high while a transaction runs
i2c_rd_data  in  16  from engine
arb_err  out  2  sticky per-requester timeout flags [1]=hk, [0]=cam; tied to 0 without the feature

Behaviour:
- Reset (n_reset low at a clk edge): all outputs 0; the FSM goes to IDLE; both armed flags are set to 1; last_grant is set to 1, so cam wins the first tie.
- Pending condition: a requester is pending when its start is high and its armed flag is 1. hk additionally requires lock_hk low.
- Arbitration:
  - Only one requester pending: that requester wins.
  - Both pending: the requester not equal to last_grant wins (alternating).
  - Sampled in IDLE only.
- Grant, clock edge N: latch grant_id, the winner's type and cmd; update last_grant; clear the winner's armed flag.
- Issue, edge N+1: i2c_start = 1, with i2c_type and i2c_cmd driven from the latches. i2c_cmd and i2c_type stay stable until the FSM returns to IDLE.
- FSM states:
  - IDLE: on a pending requester, grant it and go to ISSUE.
  - ISSUE: drive i2c_start = 1; go to WAIT_START.
  - WAIT_START: when i2c_status goes high, set i2c_start = 0, set the granted status = 1, and go to WAIT_DONE.
  - WAIT_DONE: when i2c_status goes low, capture i2c_rd_data into the granted rd_data register, set the granted status = 0, and go to RELEASE.
  - RELEASE: a single cycle, then back to IDLE.
- Re-arm: a requester's armed flag sets again on any cycle its start is low. This prevents a held-high start from triggering a second transaction.
- Non-granted requester: its status stays 0 and its rd_data holds its previous value. Its request stays pending with no loss.
- The status seen by a requester must mirror the engine's busy window, delayed by one cycle.
- lock_hk rising mid-transaction has no effect on an hk transaction already granted. It blocks only future hk grants.
- A requester dropping start mid-transaction does not abort the transaction.
- Reset mid-transaction: i2c_start drops on the next edge. The engine is expected to finish on its own, and the arbiter ignores i2c_status until it returns to IDLE.

Optional Feature:
PB_I2C_ARB_TIMEOUT_EN
- With the macro defined:
  - A watchdog counter clears on entry to ISSUE and counts in WAIT_START and WAIT_DONE.
  - When the count reaches TIMEOUT_CYCLES: drop i2c_start, set the granted requester's arb_err bit, and load 16'hDEAD into its rd_data.
  - Pulse the granted status high for exactly one cycle, then low, so the requester's handshake completes. Then go to RELEASE.
  - arb_err clears only on reset.
- Without the macro: no counter exists, arb_err = 2'b00, and the FSM waits indefinitely.

Decomposition:
- Shared package pb_i2c_pkg holds:
  - I2C type constants: I2C_WR = 0, I2C_RD = 1, I2C_RD_RS = 2.
  - The FSM state encodings.
  - Requester IDs: REQ_CAM = 0, REQ_HK = 1.
  - The 16'hDEAD error word.
- Optional sub-module pb_i2c_arb_pick: the combinational two-way alternating-priority picker with lock masking. Everything else stays in one module.

Test Plan:
- cam write alone:
  - Stimulus: cam_start = 1 with type 0 and cmd 32'h0B_16_12_34; the engine model raises status 3 cycles after i2c_start and holds it for 50 cycles.
  - Required: i2c_cmd = 32'h0B161234 and i2c_start is high one cycle after grant; cam_status is high for 50 cycles; hk_status stays 0.
- Simultaneous requests after reset:
  - Stimulus: cam and hk start on the same cycle.
  - Required: cam is granted first, hk second.
  - Stimulus: repeat the simultaneous request.
  - Required: hk is granted first (alternation), with no lost requests.
- hk read:
  - Stimulus: an hk read; the engine returns 16'h1F40.
  - Required: hk_rd_data = 16'h1F40 after status falls; cam_rd_data is unchanged.
- Held start:
  - Stimulus: cam_start held high for 3 transaction lengths.
  - Required: exactly one engine transaction; a second occurs only after a 1-cycle low on cam_start.
- Lock:
  - Stimulus: lock_hk = 1 with hk_start = 1 for 1000 cycles.
  - Required: no hk grant.
  - Stimulus: lock_hk falls.
  - Required: hk is granted within 2 cycles.
- Timeout (macro on, TIMEOUT_CYCLES = 100):
  - Stimulus: the engine never raises status.
  - Required: at cycle 100, i2c_start drops, arb_err = 2'b01, cam_rd_data = 16'hDEAD, and cam_status shows a 1-cycle pulse.

Source files
------------

// File: rtl/pb_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_i2c_pkg
// Description : Shared types and constants for the Power Board I2C arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_i2c_pkg;

  localparam logic [3:0]  I2C_WR    = 4'd0;
  localparam logic [3:0]  I2C_RD    = 4'd1;
  localparam logic [3:0]  I2C_RD_RS = 4'd2;

  localparam logic        REQ_CAM   = 1'b0;
  localparam logic        REQ_HK    = 1'b1;

  localparam logic [15:0] ERR_WORD  = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RELEASE    = 3'd4,
    ST_TIMEOUT    = 3'd5
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pb_i2c_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : pb_i2c_arb_pick
// Description : Two-way alternating-priority picker with hk lock masking.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_i2c_arb_pick
  import pb_i2c_pkg::*;
(
  input  logic i_cam_pend,
  input  logic i_hk_req,
  input  logic i_lock_hk,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  logic w_hk_pend;

  assign w_hk_pend = i_hk_req & ~i_lock_hk;

  always_comb begin
    o_valid  = i_cam_pend | w_hk_pend;
    o_winner = REQ_CAM;
    if (i_cam_pend && w_hk_pend) begin
      o_winner = ~i_last_grant;
    end else if (w_hk_pend) begin
      o_winner = REQ_HK;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pb_i2c_arbiter
// Description : Shares the PB I2C engine between cam (req 0) and hk (req 1).
//               Optional engine watchdog: define PB_I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_i2c_arbiter
  import pb_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int TO_CNT_W       = 21
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cam_start,
  input  logic [3:0]  cam_type,
  input  logic [31:0] cam_cmd,
  output logic        cam_status,
  output logic [15:0] cam_rd_data,
  input  logic        hk_start,
  input  logic [3:0]  hk_type,
  input  logic [31:0] hk_cmd,
  output logic        hk_status,
  output logic [15:0] hk_rd_data,
  input  logic        lock_hk,
  output logic        i2c_start,
  output logic [3:0]  i2c_type,
  output logic [31:0] i2c_cmd,
  input  logic        i2c_status,
  input  logic [15:0] i2c_rd_data,
  output logic [1:0]  arb_err
);

  if ((TO_CNT_W < 31) && ((1 << TO_CNT_W) <= TIMEOUT_CYCLES)) begin : g_cfg_check
    $error("pb_i2c_arbiter: TO_CNT_W too narrow for TIMEOUT_CYCLES");
  end

  arb_state_t       r_state,      w_state_nxt;
  logic             r_grant_id,   w_grant_id_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic [1:0]       r_armed,      w_armed_nxt;
  logic [3:0]       r_type,       w_type_nxt;
  logic [31:0]      r_cmd,        w_cmd_nxt;
  logic             r_i2c_start,  w_i2c_start_nxt;
  logic [1:0]       r_status,     w_status_nxt;
  logic [1:0][15:0] r_rd_data,    w_rd_data_nxt;
  logic [1:0]       w_start;
  logic             w_pick_valid;
  logic             w_pick_winner;

`ifdef PB_I2C_ARB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt_nxt, w_to_cnt_inc;
  logic [1:0]          r_arb_err, w_arb_err_nxt;

  assign w_to_cnt_inc = r_to_cnt + 1'b1;
  assign arb_err      = r_arb_err;
`else
  assign arb_err      = 2'b00;
`endif

  assign w_start = {hk_start, cam_start};

  pb_i2c_arb_pick u_pick (
    .i_cam_pend   (cam_start & r_armed[REQ_CAM]),
    .i_hk_req     (hk_start & r_armed[REQ_HK]),
    .i_lock_hk    (lock_hk),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_winner     (w_pick_winner)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_id_nxt   = r_grant_id;
    w_last_grant_nxt = r_last_grant;
    w_armed_nxt      = r_armed;
    w_type_nxt       = r_type;
    w_cmd_nxt        = r_cmd;
    w_i2c_start_nxt  = r_i2c_start;
    w_status_nxt     = r_status;
    w_rd_data_nxt    = r_rd_data;

    // A low start re-arms; a held-high start cannot launch a second transaction.
    for (int i = 0; i < 2; i++) begin
      if (!w_start[i]) w_armed_nxt[i] = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant_id_nxt             = w_pick_winner;
          w_last_grant_nxt           = w_pick_winner;
          w_armed_nxt[w_pick_winner] = 1'b0;
          w_type_nxt                 = (w_pick_winner == REQ_HK) ? hk_type : cam_type;
          w_cmd_nxt                  = (w_pick_winner == REQ_HK) ? hk_cmd  : cam_cmd;
          w_state_nxt                = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_i2c_start_nxt = 1'b1;
        w_state_nxt     = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (i2c_status) begin
          w_i2c_start_nxt          = 1'b0;
          w_status_nxt[r_grant_id] = 1'b1;
          w_state_nxt              = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!i2c_status) begin
          w_rd_data_nxt[r_grant_id] = i2c_rd_data;
          w_status_nxt[r_grant_id]  = 1'b0;
          w_state_nxt               = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_TIMEOUT: begin
        w_status_nxt[r_grant_id] = 1'b0;
        w_state_nxt              = ST_RELEASE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

`ifdef PB_I2C_ARB_TIMEOUT_EN
    w_to_cnt_nxt  = r_to_cnt;
    w_arb_err_nxt = r_arb_err;
    if (r_state == ST_ISSUE) begin
      w_to_cnt_nxt = '0;
    end else if ((r_state == ST_WAIT_START) || (r_state == ST_WAIT_DONE)) begin
      w_to_cnt_nxt = w_to_cnt_inc;
      // Expiry overrides the normal handshake; status pulses for one cycle in ST_TIMEOUT.
      if (w_to_cnt_inc == TO_CNT_W'(TIMEOUT_CYCLES)) begin
        w_i2c_start_nxt           = 1'b0;
        w_arb_err_nxt[r_grant_id] = 1'b1;
        w_rd_data_nxt[r_grant_id] = ERR_WORD;
        w_status_nxt[r_grant_id]  = 1'b1;
        w_state_nxt               = ST_TIMEOUT;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= REQ_CAM;
      r_last_grant <= REQ_HK;
      r_armed      <= 2'b11;
      r_type       <= '0;
      r_cmd        <= '0;
      r_i2c_start  <= 1'b0;
      r_status     <= '0;
      r_rd_data    <= '0;
`ifdef PB_I2C_ARB_TIMEOUT_EN
      r_to_cnt     <= '0;
      r_arb_err    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_armed      <= w_armed_nxt;
      r_type       <= w_type_nxt;
      r_cmd        <= w_cmd_nxt;
      r_i2c_start  <= w_i2c_start_nxt;
      r_status     <= w_status_nxt;
      r_rd_data    <= w_rd_data_nxt;
`ifdef PB_I2C_ARB_TIMEOUT_EN
      r_to_cnt     <= w_to_cnt_nxt;
      r_arb_err    <= w_arb_err_nxt;
`endif
    end
  end

  assign i2c_start   = r_i2c_start;
  assign i2c_type    = r_type;
  assign i2c_cmd     = r_cmd;
  assign cam_status  = r_status[REQ_CAM];
  assign hk_status   = r_status[REQ_HK];
  assign cam_rd_data = r_rd_data[REQ_CAM];
  assign hk_rd_data  = r_rd_data[REQ_HK];

endmodule
`default_nettype wire
